input_queue_route: RTL and testbench

INPUT_QUEUE_ROUTE -- requirements
Module: input_queue_route

---
 rtl/input_queue_route.sv | 131 +++++++++++++
 tb/tb_input_queue_route.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/input_queue_route.sv
// input_queue_route: router input queue with dimension-order (X, then Y, then Z) route
// computation done at enqueue time.
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-low reset (clears pointers and count only)
//   in_flit    - incoming flit; destination coordinates live in the low 3*COORD_W bits
//   in_valid   - in_flit is valid this cycle
//   in_ready   - queue accepts a flit this cycle (not full)
//   out_flit   - head flit, zero when empty
//   out_route  - head flit's output direction, zero (INJECT) when empty
//   out_valid  - head flit is valid
//   out_avail  - downstream switch slot is free; head is consumed when high with out_valid
module input_queue_route #(
  parameter int unsigned FLIT_SIZE    = 82,
  parameter int unsigned ROUTE_LEN    = 3,
  parameter int unsigned input_Q_size = 5,
  parameter int unsigned COORD_W      = 4,
  parameter int unsigned cur_x        = 0,
  parameter int unsigned cur_y        = 0,
  parameter int unsigned cur_z        = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [FLIT_SIZE-1:0] in_flit,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [FLIT_SIZE-1:0] out_flit,
  output logic [ROUTE_LEN-1:0] out_route,
  output logic                 out_valid,
  input  logic                 out_avail
);

  localparam int unsigned PtrW = (input_Q_size > 1) ? $clog2(input_Q_size) : 1;
  localparam int unsigned CntW = $clog2(input_Q_size + 1);

  localparam logic [PtrW-1:0] LastPtr = PtrW'(input_Q_size - 1);
  localparam logic [CntW-1:0] Depth   = CntW'(input_Q_size);

  localparam logic [COORD_W-1:0] CurX = COORD_W'(cur_x);
  localparam logic [COORD_W-1:0] CurY = COORD_W'(cur_y);
  localparam logic [COORD_W-1:0] CurZ = COORD_W'(cur_z);

  localparam logic [ROUTE_LEN-1:0] RouteXPos  = ROUTE_LEN'(1);
  localparam logic [ROUTE_LEN-1:0] RouteYPos  = ROUTE_LEN'(2);
  localparam logic [ROUTE_LEN-1:0] RouteZPos  = ROUTE_LEN'(3);
  localparam logic [ROUTE_LEN-1:0] RouteXNeg  = ROUTE_LEN'(4);
  localparam logic [ROUTE_LEN-1:0] RouteYNeg  = ROUTE_LEN'(5);
  localparam logic [ROUTE_LEN-1:0] RouteZNeg  = ROUTE_LEN'(6);
  localparam logic [ROUTE_LEN-1:0] RouteEject = ROUTE_LEN'(7);

  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CntW-1:0] count_q, count_d;

  // Storage is deliberately not reset; validity is tracked by count_q alone.
  logic [FLIT_SIZE-1:0] flit_mem [input_Q_size];
  logic [ROUTE_LEN-1:0] route_mem[input_Q_size];

  logic [COORD_W-1:0]   dst_x, dst_y, dst_z;
  logic [ROUTE_LEN-1:0] in_route;
  logic                 push, pop;

  assign dst_x = in_flit[3*COORD_W-1:2*COORD_W];
  assign dst_y = in_flit[2*COORD_W-1:COORD_W];
  assign dst_z = in_flit[COORD_W-1:0];

  // Route is resolved on the incoming flit and stored alongside it, so the head's route
  // never depends on whatever is currently on in_flit.
  always_comb begin
    in_route = RouteEject;
    if (dst_x != CurX) begin
      in_route = (dst_x > CurX) ? RouteXPos : RouteXNeg;
    end else if (dst_y != CurY) begin
      in_route = (dst_y > CurY) ? RouteYPos : RouteYNeg;
    end else if (dst_z != CurZ) begin
      in_route = (dst_z > CurZ) ? RouteZPos : RouteZNeg;
    end
  end

  assign in_ready  = (count_q != Depth);
  assign out_valid = (count_q != '0);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_avail;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = (wr_ptr_q == LastPtr) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop) begin
      rd_ptr_d = (rd_ptr_q == LastPtr) ? '0 : rd_ptr_q + 1'b1;
    end
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      flit_mem[wr_ptr_q]  <= in_flit;
      route_mem[wr_ptr_q] <= in_route;
    end
  end

  always_comb begin
    out_flit  = '0;
    out_route = '0;
    if (out_valid) begin
      out_flit  = flit_mem[rd_ptr_q];
      out_route = route_mem[rd_ptr_q];
    end
  end

endmodule

// File: tb/tb_input_queue_route.sv
module tb_input_queue_route;

  localparam int FW    = 82;
  localparam int DEPTH = 5;

  logic          clk = 1'b0;
  logic          rst;
  logic [FW-1:0] in_flit;
  logic          in_valid;
  logic          in_ready;
  logic [FW-1:0] out_flit;
  logic [2:0]    out_route;
  logic          out_valid;
  logic          out_avail;

  // Second instance at node (3,3,3) for route checks away from the origin.
  logic [FW-1:0] in3_flit;
  logic          in3_valid;
  logic          in3_ready;
  logic [FW-1:0] out3_flit;
  logic [2:0]    out3_route;
  logic          out3_valid;
  logic          out3_avail;

  int nvec  = 0;
  int nfail = 0;
  int pushed_cnt = 0;

  logic [FW-1:0] mq[$];

  always #5 clk = ~clk;

  input_queue_route u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in_flit),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_flit  (out_flit),
    .out_route (out_route),
    .out_valid (out_valid),
    .out_avail (out_avail)
  );

  input_queue_route #(
    .cur_x (3),
    .cur_y (3),
    .cur_z (3)
  ) u_dut3 (
    .clk       (clk),
    .rst       (rst),
    .in_flit   (in3_flit),
    .in_valid  (in3_valid),
    .in_ready  (in3_ready),
    .out_flit  (out3_flit),
    .out_route (out3_route),
    .out_valid (out3_valid),
    .out_avail (out3_avail)
  );

  function automatic logic [FW-1:0] mk(int dx, int dy, int dz, int tag);
    logic [FW-1:0] f;
    f = '0;
    f[81:12] = 70'(tag);
    f[11:8]  = 4'(dx);
    f[7:4]   = 4'(dy);
    f[3:0]   = 4'(dz);
    return f;
  endfunction

  // Dimension-order routing straight from the rule: first differing axis decides.
  function automatic logic [2:0] route_of(logic [FW-1:0] f, int cx, int cy, int cz);
    int d[3];
    int c[3];
    d[0] = int'(f[11:8]);
    d[1] = int'(f[7:4]);
    d[2] = int'(f[3:0]);
    c[0] = cx;
    c[1] = cy;
    c[2] = cz;
    for (int a = 0; a < 3; a++) begin
      if (d[a] > c[a]) return 3'(a + 1);
      if (d[a] < c[a]) return 3'(a + 4);
    end
    return 3'd7;
  endfunction

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  // Reference FIFO: a plain queue of flits, bounded at DEPTH.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
    end else if (in_valid && mq.size() < DEPTH) begin
      if (out_avail && mq.size() > 0) void'(mq.pop_front());
      mq.push_back(in_flit);
      pushed_cnt <= pushed_cnt + 1;
    end else if (out_avail && mq.size() > 0) begin
      void'(mq.pop_front());
    end
  end

  always @(negedge clk) begin
    chk("out_valid", 128'(out_valid), 128'(mq.size() != 0));
    chk("in_ready", 128'(in_ready), 128'(mq.size() < DEPTH));
    chk("out_flit", 128'(out_flit), (mq.size() != 0) ? 128'(mq[0]) : 128'(0));
    chk("out_route", 128'(out_route),
        (mq.size() != 0) ? 128'(route_of(mq[0], 0, 0, 0)) : 128'(0));
  end

  initial begin
    rst        = 1'b0;
    in_flit    = '0;
    in_valid   = 1'b0;
    out_avail  = 1'b0;
    in3_flit   = '0;
    in3_valid  = 1'b0;
    out3_avail = 1'b0;
    #1;
    chk("rst_valid", 128'(out_valid), 128'(0));
    chk("rst_flit", 128'(out_flit), 128'(0));
    chk("rst_route", 128'(out_route), 128'(0));
    chk("rst_ready", 128'(in_ready), 128'(1));
    step();
    rst = 1'b1;

    // Single flit toward +X: visible next cycle, gone after one pop.
    in_flit   = mk(2, 0, 0, 1);
    in_valid  = 1'b1;
    out_avail = 1'b1;
    step();
    in_valid = 1'b0;
    chk("xpos_valid", 128'(out_valid), 128'(1));
    chk("xpos_route", 128'(out_route), 128'(1));
    step();
    chk("xpos_gone_valid", 128'(out_valid), 128'(0));
    chk("xpos_gone_route", 128'(out_route), 128'(0));

    // Overfill while blocked, then drain in order.
    out_avail = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      in_flit  = mk(i, 1, 2, i);
      in_valid = 1'b1;
      step();
      if (i == 5) chk("full_ready", 128'(in_ready), 128'(0));
    end
    in_valid  = 1'b0;
    out_avail = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      chk("drain_order", 128'(out_flit[81:12]), 128'(i));
      step();
    end
    chk("drain_empty", 128'(out_valid), 128'(0));

    // Full queue: first cycle pops only, next cycle pushes and pops.
    out_avail = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      in_flit  = mk(0, i, 0, i);
      in_valid = 1'b1;
      step();
    end
    in_flit   = mk(0, 0, 4, 20);
    out_avail = 1'b1;
    step();
    chk("popfull_ready", 128'(in_ready), 128'(1));
    chk("popfull_head", 128'(out_flit[81:12]), 128'(2));
    in_flit = mk(0, 0, 4, 21);
    step();
    in_valid = 1'b0;
    chk("pushpop_ready", 128'(in_ready), 128'(1));
    chk("pushpop_head", 128'(out_flit[81:12]), 128'(3));
    repeat (6) step();
    chk("pp_drained", 128'(out_valid), 128'(0));

    // Mid-operation reset discards queued flits.
    out_avail = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      in_flit  = mk(5, 5, 5, 40 + i);
      in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("mrst_valid", 128'(out_valid), 128'(0));
    chk("mrst_ready", 128'(in_ready), 128'(1));
    chk("mrst_flit", 128'(out_flit), 128'(0));
    rst = 1'b1;
    in_flit  = mk(0, 2, 0, 99);
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    chk("mrst_new_head", 128'(out_flit[81:12]), 128'(99));
    chk("mrst_new_route", 128'(out_route), 128'(2));
    out_avail = 1'b1;
    step();

    // Random traffic against the reference queue; pointers wrap many times.
    for (int n = 0; n < 400 && pushed_cnt < 60; n++) begin
      in_flit   = mk($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                     int'($urandom));
      if ($urandom_range(0, 3) == 0) in_flit[11:0] = '0;
      in_valid  = ($urandom_range(0, 3) != 0);
      out_avail = ($urandom_range(0, 2) != 0);
      step();
    end
    chk("rand_enough", 128'(pushed_cnt >= 20), 128'(1));
    in_valid  = 1'b0;
    out_avail = 1'b1;
    repeat (DEPTH + 1) step();

    // Routes at node (3,3,3).
    in3_valid = 1'b1;
    in3_flit = mk(1, 5, 5, 1); step();
    in3_flit = mk(3, 5, 0, 2); step();
    in3_flit = mk(3, 3, 0, 3); step();
    in3_flit = mk(3, 3, 3, 4); step();
    in3_valid = 1'b0;
    chk("n3_route_xneg", 128'(out3_route), 128'(4));
    out3_avail = 1'b1;
    step();
    chk("n3_route_ypos", 128'(out3_route), 128'(2));
    step();
    chk("n3_route_zneg", 128'(out3_route), 128'(6));
    step();
    chk("n3_route_eject", 128'(out3_route), 128'(7));
    step();
    chk("n3_empty", 128'(out3_valid), 128'(0));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
